// File: rtl/curve_lut_ctrl.sv
// curve_lut_ctrl: double-buffered 256-entry tone-curve LUT applied to an 8-bit gray video stream.
// The datapath reads the active bank. Host writes go to the shadow bank, and a commit swaps the
// banks at the next frame start so that no frame mixes two curves.
// Optional feature: define CURVE_LUT_READBACK_EN to add a 1-cycle shadow-bank read port.
module curve_lut_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_gray,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_gray,
  input  logic              lut_wr_en,
  input  logic [7:0]        lut_wr_addr,
  input  logic [DATA_W-1:0] lut_wr_data,
  input  logic              lut_commit,
  input  logic              cfg_bypass,
  output logic              lut_busy,
  output logic              lut_done,
  output logic              active_bank
`ifdef CURVE_LUT_READBACK_EN
  ,
  input  logic [7:0]        lut_rd_addr,
  output logic [DATA_W-1:0] lut_rd_data
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StPend, StSwap} state_e;

  state_e r_state, w_state_d;

  logic [DATA_W-1:0] r_bank0 [0:255];
  logic [DATA_W-1:0] r_bank1 [0:255];

  logic              r_active_bank;
  logic              r_bank_valid;
  logic              r_vsync_q;
  logic              r_bypass;
  logic              w_frame_start;
  logic              w_shadow_we;

  // Stage-1 pipeline registers
  logic              r_vsync1, r_href1, r_clken1, r_use1;
  logic [DATA_W-1:0] r_pix1;
  logic [DATA_W-1:0] r_lut1;

  assign w_frame_start = per_frame_vsync & ~r_vsync_q;
  assign active_bank   = r_active_bank;

  // Control state: FSM, bank select, vsync edge detect and per-frame bypass sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_active_bank <= 1'b0;
      r_bank_valid  <= 1'b0;
      r_vsync_q     <= 1'b0;
      r_bypass      <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_vsync_q <= per_frame_vsync;
      if (w_frame_start) r_bypass <= cfg_bypass;
      // Bank select only moves here, one cycle after a frame start
      if (r_state == StSwap) begin
        r_active_bank <= ~r_active_bank;
        r_bank_valid  <= 1'b1;
      end
    end
  end

  // Next-state logic, shadow write gating and status outputs
  always_comb begin
    w_state_d   = r_state;
    w_shadow_we = 1'b0;
    lut_busy    = 1'b0;
    lut_done    = 1'b0;
    case (r_state)
      StIdle: begin
        w_shadow_we = lut_wr_en;
        if (lut_commit)     w_state_d = StPend;
        else if (lut_wr_en) w_state_d = StLoad;
      end
      StLoad: begin
        w_shadow_we = lut_wr_en;
        if (lut_commit) w_state_d = StPend;
      end
      StPend: begin
        // Writes ignored here so the pending curve cannot change under the swap
        lut_busy = 1'b1;
        if (w_frame_start) w_state_d = StSwap;
      end
      StSwap: begin
        lut_busy  = 1'b1;
        lut_done  = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Shadow-bank write port; bank contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_shadow_we) begin
      if (r_active_bank) r_bank0[lut_wr_addr] <= lut_wr_data;
      else               r_bank1[lut_wr_addr] <= lut_wr_data;
    end
  end

  // Stage-1 active-bank lookup, addressed by the incoming pixel
  always_ff @(posedge clk) begin
    r_lut1 <= r_active_bank ? r_bank1[per_img_gray] : r_bank0[per_img_gray];
  end

  // Stage 1: register input pixel, syncs and the map/bypass decision for this pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync1 <= 1'b0;
      r_href1  <= 1'b0;
      r_clken1 <= 1'b0;
      r_pix1   <= '0;
      r_use1   <= 1'b0;
    end else begin
      r_vsync1 <= per_frame_vsync;
      r_href1  <= per_frame_href;
      r_clken1 <= per_frame_clken;
      r_pix1   <= per_img_gray;
      r_use1   <= r_bank_valid & ~r_bypass;
    end
  end

  // Stage 2: register the selected output and the delayed syncs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_gray    <= '0;
    end else begin
      post_frame_vsync <= r_vsync1;
      post_frame_href  <= r_href1;
      post_frame_clken <= r_clken1;
      post_img_gray    <= r_use1 ? r_lut1 : r_pix1;
    end
  end

`ifdef CURVE_LUT_READBACK_EN
  // Shadow-bank readback with one cycle of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_rd_data <= '0;
    end else begin
      lut_rd_data <= r_active_bank ? r_bank0[lut_rd_addr] : r_bank1[lut_rd_addr];
    end
  end
`endif

endmodule

// File: tb/tb_curve_lut_ctrl.sv
// Testbench for curve_lut_ctrl: directed frames, scoreboard of expected pixels checked by a
// negedge monitor, plus direct checks of the LUT control status outputs.
module tb_curve_lut_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
  logic [7:0] per_img_gray = 8'h00;
  logic       post_frame_vsync, post_frame_href, post_frame_clken;
  logic [7:0] post_img_gray;
  logic       lut_wr_en = 1'b0;
  logic [7:0] lut_wr_addr = 8'h00, lut_wr_data = 8'h00;
  logic       lut_commit = 1'b0, cfg_bypass = 1'b0;
  logic       lut_busy, lut_done, active_bank;
`ifdef CURVE_LUT_READBACK_EN
  logic [7:0] lut_rd_addr = 8'h00;
  logic [7:0] lut_rd_data;
`endif

  typedef struct packed {
    logic [7:0]  g;
    logic [31:0] c;
  } exp_t;

  exp_t       sb[$];
  exp_t       e_mon;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         d0;
  logic [2:0] h1, h2;

  always #5 clk = ~clk;

  curve_lut_ctrl #(.DATA_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_gray     (per_img_gray),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_gray    (post_img_gray),
    .lut_wr_en        (lut_wr_en),
    .lut_wr_addr      (lut_wr_addr),
    .lut_wr_data      (lut_wr_data),
    .lut_commit       (lut_commit),
    .cfg_bypass       (cfg_bypass),
    .lut_busy         (lut_busy),
    .lut_done         (lut_done),
    .active_bank      (active_bank)
`ifdef CURVE_LUT_READBACK_EN
    ,
    .lut_rd_addr      (lut_rd_addr),
    .lut_rd_data      (lut_rd_data)
`endif
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Test curve: 0x7F -> 0x80, 0xFF -> 0xF0
  function automatic logic [7:0] curve_a(input logic [7:0] x);
    if (x < 8'h80) return x + 8'd1;
    return 8'hF0 - ((8'hFF - x) >> 2);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Two-cycle reference delay of the input syncs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 <= 3'b000;
      h2 <= 3'b000;
    end else begin
      h1 <= {per_frame_vsync, per_frame_href, per_frame_clken};
      h2 <= h1;
    end
  end

  // Monitor: sync delay every cycle, pixels popped from the scoreboard on clken
  always @(negedge clk) begin
    chk("sync_delay", 32'({post_frame_vsync, post_frame_href, post_frame_clken}), 32'(h2));
    if (rst_n && lut_done) done_cnt++;
    if (rst_n && post_frame_clken) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pix_unexpected: got %02h, expected no pixel", post_img_gray);
      end else begin
        e_mon = sb.pop_front();
        chk("pix", 32'(post_img_gray), 32'(e_mon.g));
        chk("pix_latency", 32'(cyc), e_mon.c + 32'd2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] v, input logic [7:0] e);
    exp_t t;
    per_frame_href  = 1'b1;
    per_frame_clken = 1'b1;
    per_img_gray    = v;
    t.g = e;
    t.c = 32'(cyc);
    sb.push_back(t);
    tick();
    per_frame_clken = 1'b0;
    per_img_gray    = 8'hAA;
    tick();
    per_frame_href  = 1'b0;
  endtask

  task automatic vsync_pulse(input bit commit);
    per_frame_vsync = 1'b1;
    lut_commit      = commit;
    tick();
    lut_commit      = 1'b0;
    tick();
    tick();
    per_frame_vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic write_one(input logic [7:0] a, input logic [7:0] d);
    lut_wr_en   = 1'b1;
    lut_wr_addr = a;
    lut_wr_data = d;
    tick();
    lut_wr_en   = 1'b0;
  endtask

  task automatic write_curve(input bit inv);
    for (int i = 0; i < 256; i++) begin
      lut_wr_en   = 1'b1;
      lut_wr_addr = 8'(i);
      lut_wr_data = inv ? ~8'(i) : curve_a(8'(i));
      tick();
    end
    lut_wr_en = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_post_gray", 32'(post_img_gray), 32'h00);
    chk("rst_lut_busy", 32'(lut_busy), 32'h0);
    chk("rst_lut_done", 32'(lut_done), 32'h0);
    chk("rst_active_bank", 32'(active_bank), 32'h0);
`ifdef CURVE_LUT_READBACK_EN
    chk("rst_rd_data", 32'(lut_rd_data), 32'h00);
`endif
    rst_n = 1'b1;
    tick();

    // No valid bank yet: pass-through
    repeat (2) begin
      vsync_pulse(1'b0);
      send_pix(8'h40, 8'h40);
      send_pix(8'hC3, 8'hC3);
    end
    chk("idle_busy", 32'(lut_busy), 32'h0);
    chk("idle_bank", 32'(active_bank), 32'h0);

    // Load curve, commit mid-frame, stray write while pending
    write_curve(1'b0);
    vsync_pulse(1'b0);
    send_pix(8'h7F, 8'h7F);
    lut_commit = 1'b1;
    tick();
    lut_commit = 1'b0;
    chk("pend_busy", 32'(lut_busy), 32'h1);
    write_one(8'h7F, 8'h00);
    send_pix(8'hFF, 8'hFF);
    chk("pend_busy_hold", 32'(lut_busy), 32'h1);
    chk("pend_bank", 32'(active_bank), 32'h0);
    d0 = done_cnt;
    vsync_pulse(1'b0);
    chk("swap_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("swap_busy", 32'(lut_busy), 32'h0);
    chk("swap_bank", 32'(active_bank), 32'h1);
    send_pix(8'h7F, 8'h80);
    send_pix(8'hFF, 8'hF0);
    send_pix(8'h00, 8'h01);
    send_pix(8'h80, 8'hD1);
    send_pix(8'h40, 8'h41);

    // Commit coincident with vsync rise swaps only on the following rise
    write_curve(1'b1);
    d0 = done_cnt;
    vsync_pulse(1'b1);
    chk("coinc_no_done", 32'(done_cnt - d0), 32'd0);
    chk("coinc_busy", 32'(lut_busy), 32'h1);
    chk("coinc_bank", 32'(active_bank), 32'h1);
    send_pix(8'h12, 8'h13);
    vsync_pulse(1'b0);
    chk("coinc_done", 32'(done_cnt - d0), 32'd1);
    chk("coinc_bank2", 32'(active_bank), 32'h0);
    chk("coinc_busy2", 32'(lut_busy), 32'h0);
    send_pix(8'h12, 8'hED);
    send_pix(8'hFF, 8'h00);

    // Bypass raised mid-frame takes effect at the next frame only
    cfg_bypass = 1'b1;
    send_pix(8'h12, 8'hED);
    vsync_pulse(1'b0);
    send_pix(8'h12, 8'h12);
    send_pix(8'hFF, 8'hFF);
    cfg_bypass = 1'b0;
    vsync_pulse(1'b0);
    send_pix(8'h12, 8'hED);

    // Reset while pending discards the swap
    write_one(8'h00, 8'h33);
    lut_commit = 1'b1;
    tick();
    lut_commit = 1'b0;
    chk("rp_busy", 32'(lut_busy), 32'h1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #2;
    chk("rp_busy_rst", 32'(lut_busy), 32'h0);
    chk("rp_done_rst", 32'(lut_done), 32'h0);
    chk("rp_bank_rst", 32'(active_bank), 32'h0);
    chk("rp_gray_rst", 32'(post_img_gray), 32'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vsync_pulse(1'b0);
    chk("rp_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rp_busy_after", 32'(lut_busy), 32'h0);
    chk("rp_bank_after", 32'(active_bank), 32'h0);
    send_pix(8'h40, 8'h40);

`ifdef CURVE_LUT_READBACK_EN
    write_one(8'h10, 8'h5A);
    lut_rd_addr = 8'h10;
    tick();
    chk("readback", 32'(lut_rd_data), 32'h5A);
`endif

    repeat (4) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
